warp_lane_skid: RTL and testbench
=================================

Name: warp_lane_skid

Overview:
- Multi-lane, multi-entry skid FIFO placed between stages of the dual-issue (generally LANES-issue) pipeline.
- Accepts 0..LANES entries per cycle and presents the oldest 0..LANES entries per cycle.
- Absorbs partial consumption, where a stage takes one of two instructions, and smooths out bursty rates.
- Successor to the single-entry skid buffer: count-based handshake instead of single ready/valid, with parametrised lanes and depth.

Parameters:
- WIDTH, 32, bits per entry (one instruction/payload).
- LANES, 2, max entries written and read per cycle; >= 1.
- DEPTH, 4, storage entries; >= LANES; need not be a power of two.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset; assert async, release sync to i_clk.
- i_wcount  in  CW  number of valid write lanes this cycle, packed from lane 0; CW = $clog2(LANES+1).
- i_wdata  in  LANES*WIDTH  write lanes; lane k at bits [k*WIDTH +: WIDTH]; lane 0 is oldest.
- o_wcapacity  out  CW  entries the block will accept this cycle.
- o_rcount  out  CW  valid read lanes presented, packed from lane 0.
- o_rdata  out  LANES*WIDTH  oldest entries; lane 0 is the oldest.
- i_rtake  in  CW  number of presented entries the consumer takes this cycle.

Behaviour:
- State: storage[DEPTH], head pointer, tail pointer (width $clog2(DEPTH), minimum 1), occupancy occ (width $clog2(DEPTH+1)).
- Reset: occ=0, head=tail=0, storage cleared to 0. Outputs on reset: o_wcapacity=LANES, o_rcount=0, o_rdata=0.
- Outputs are functions of registered state only; there is no combinational path from any input to any output.
  - o_wcapacity = min(DEPTH-occ, LANES). It is conservative: it does not count same-cycle reads.
  - o_rcount = min(occ, LANES).
  - o_rdata lane k = storage[(head+k) mod DEPTH] for k < o_rcount; lanes k >= o_rcount are driven 0.
- Accepted counts:
  - wacc = min(i_wcount, o_wcapacity).
  - racc = min(i_rtake, o_rcount).
  - Excess requests are silently dropped. This is a protocol violation, flagged in formal, and never corrupts state.
- Write: lanes 0..wacc-1 go to storage[(tail+k) mod DEPTH]; tail advances by wacc.
- Read: head advances by racc.
- occ_next = occ + wacc - racc. Range is 0..DEPTH by construction.
- Latency: an entry written in cycle N is visible on o_rdata at N+1 at the earliest; there is no empty-bypass.
- Wrap-around: pointer advance uses an explicit compare-and-subtract (p+n >= DEPTH ? p+n-DEPTH : p+n), valid for any DEPTH.
- Simultaneous read and write:
  - Both apply in the same cycle.
  - At full occupancy the write is refused (capacity 0) even if a read frees space that cycle.
  - The freed space shows up in o_wcapacity next cycle.
- Ordering: strict FIFO across lanes and cycles; lane order within a write is preserved.
- Reset mid-operation: all contents are discarded immediately (async) and outputs take their reset values in the same instant.
- Formal (WARP_FORMAL):
  - assert occ <= DEPTH.
  - assert o_rcount + o_wcapacity <= occ + LANES.
  - assume i_wcount <= o_wcapacity and i_rtake <= o_rcount.
  - cover full, empty, partial read, and wrap events.

Optional Feature:
- Macro: WARP_LANE_SKID_FLUSH_EN.
- With the macro defined: adds input i_flush (1 bit, synchronous).
  - When i_flush=1 at a clock edge: occ=0 and head=tail=0 after the edge.
  - Any same-cycle write and take are discarded.
  - Storage contents are left stale. o_rdata still reads 0 because o_rcount=0.
  - Flush has priority over write and read.
  - Used for pipeline redirect on branch mispredict.
- Without the macro: no i_flush port; contents are discarded only by reset.

Test Plan (WIDTH=8, LANES=2, DEPTH=4):
- Reset asserted mid-stream with occ=3 -> immediately o_rcount=0, o_wcapacity=2, o_rdata=0x0000; after release, writing 0xA1 gives o_rdata lane0=0xA1 next cycle.
- Empty; i_wcount=2, i_wdata={0xB2,0xA1}, i_rtake=0 -> next cycle o_rcount=2, lane0=0xA1, lane1=0xB2, o_wcapacity=2.
- Write 0xC3,0xD4 with no take -> occ=4, o_wcapacity=0; then i_wcount=2 with 0xEE,0xFF -> dropped, occ stays 4, o_rdata still 0xA1/0xB2.
- occ=4, i_rtake=1 -> next cycle lane0=0xB2, lane1=0xC3, o_wcapacity=1. Then i_wcount=2 with 0x11,0x22 and i_rtake=2 -> only 0x11 accepted; next cycle occ=2, lanes 0xD4/0x11.
- Ten cycles of single write (0x01..0x0A) with i_rtake=1 from cycle 2 -> output order exactly 0x01..0x0A across pointer wrap, occ stays 1.
- (FLUSH_EN) occ=3, i_flush=1 with i_wcount=2 and i_rtake=1 in the same cycle -> next cycle occ=0, o_rcount=0, o_wcapacity=2, o_rdata=0; the next write appears at lane0.

Source files
------------

// File: rtl/warp_lane_skid.sv
// Multi-lane skid FIFO: accepts 0..LANES entries per cycle and presents the oldest 0..LANES.
// Latency: a write at cycle N is visible on o_rdata at N+1 at the earliest. There is no empty bypass.
// Backpressure: o_wcapacity is derived from registered occupancy only, so space freed by a read shows up next cycle.
//
// Ports:
//   i_clk, i_rst_n   clock; async active-low reset, released synchronously by the environment
//   i_wcount/i_wdata write count (packed from lane 0) and write lanes; lane 0 is the oldest
//   o_wcapacity      entries accepted this cycle = min(DEPTH-occ, LANES)
//   o_rcount/o_rdata presented count and oldest entries; lanes at or above o_rcount read as 0
//   i_rtake          number of presented entries the consumer takes
//   i_flush          present only with WARP_LANE_SKID_FLUSH_EN; synchronous empty, takes priority
// WARP_FORMAL adds the occupancy invariants, the protocol assumptions and covers.
module warp_lane_skid #(
  parameter int WIDTH = 32,
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
`ifdef WARP_LANE_SKID_FLUSH_EN
  input  logic                            i_flush,
`endif
  input  logic [$clog2(LANES+1)-1:0]      i_wcount,
  input  logic [LANES*WIDTH-1:0]          i_wdata,
  output logic [$clog2(LANES+1)-1:0]      o_wcapacity,
  output logic [$clog2(LANES+1)-1:0]      o_rcount,
  output logic [LANES*WIDTH-1:0]          o_rdata,
  input  logic [$clog2(LANES+1)-1:0]      i_rtake
);

  localparam int CW = $clog2(LANES+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH+1);
  // XW holds pointer+count without overflow: both terms are below/at DEPTH.
  localparam int XW = OW + 1;
  localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH);
  localparam logic [XW-1:0] LANES_X = XW'(LANES);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [OW-1:0]    occ_q, occ_d;

  logic [XW-1:0] occ_x, space_x, wcap_x, rcnt_x, wacc_x, racc_x;
  logic          flush_w;

  // Compare-and-subtract wrap; valid for any DEPTH since the sum stays below 2*DEPTH.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [XW-1:0] n);
    logic [XW-1:0] s;
    s = XW'(p) + n;
    if (s >= DEPTH_X) s = s - DEPTH_X;
    return s[PW-1:0];
  endfunction

`ifdef WARP_LANE_SKID_FLUSH_EN
  assign flush_w = i_flush;
`else
  assign flush_w = 1'b0;
`endif

  always_comb begin
    occ_x   = XW'(occ_q);
    space_x = DEPTH_X - occ_x;
    wcap_x  = (space_x < LANES_X) ? space_x : LANES_X;
    rcnt_x  = (occ_x < LANES_X) ? occ_x : LANES_X;
    // Requests beyond what is offered are clipped, never allowed to corrupt state.
    wacc_x  = (XW'(i_wcount) < wcap_x) ? XW'(i_wcount) : wcap_x;
    racc_x  = (XW'(i_rtake) < rcnt_x) ? XW'(i_rtake) : rcnt_x;
    occ_d   = OW'(occ_x + wacc_x - racc_x);
    head_d  = ptr_add(head_q, racc_x);
    tail_d  = ptr_add(tail_q, wacc_x);
  end

  assign o_wcapacity = CW'(wcap_x);
  assign o_rcount    = CW'(rcnt_x);

  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < LANES; k++) begin
      if (XW'(k) < rcnt_x) o_rdata[k*WIDTH +: WIDTH] = mem_q[ptr_add(head_q, XW'(k))];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (flush_w) begin
      // Storage is left stale; o_rcount=0 masks it on o_rdata.
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      for (int k = 0; k < LANES; k++) begin
        if (XW'(k) < wacc_x) mem_q[ptr_add(tail_q, XW'(k))] <= i_wdata[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef WARP_FORMAL
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assume (XW'(i_wcount) <= wcap_x);
      assume (XW'(i_rtake) <= rcnt_x);
      assert (occ_x <= DEPTH_X);
      assert (XW'(o_rcount) + XW'(o_wcapacity) <= occ_x + LANES_X);
      cover (occ_x == DEPTH_X);
      cover (occ_x == '0);
      cover (racc_x != '0 && racc_x < rcnt_x);
      cover (racc_x != '0 && head_d < head_q);
    end
  end
`endif

endmodule

// File: tb/tb_warp_lane_skid.sv
module tb_warp_lane_skid;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  wcount;
  logic [15:0] wdata;
  logic [1:0]  wcap;
  logic [1:0]  rcount;
  logic [15:0] rdata;
  logic [1:0]  rtake;

  int checks;
  int failures;

  typedef struct {
    logic [1:0]  wc;
    logic [15:0] wd;
    logic [1:0]  rt;
    logic [1:0]  e_rc;
    logic [1:0]  e_wc;
    logic [15:0] e_rd;
  } vec_t;

  vec_t vecs[10];

  warp_lane_skid #(.WIDTH(8), .LANES(2), .DEPTH(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
`ifdef WARP_LANE_SKID_FLUSH_EN
    .i_flush     (flush),
`endif
    .i_wcount    (wcount),
    .i_wdata     (wdata),
    .o_wcapacity (wcap),
    .o_rcount    (rcount),
    .o_rdata     (rdata),
    .i_rtake     (rtake)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] e_rc, input logic [1:0] e_wc,
                         input logic [15:0] e_rd);
    chk({tag, " rcount"}, 32'(rcount), 32'(e_rc));
    chk({tag, " wcap"}, 32'(wcap), 32'(e_wc));
    chk({tag, " rdata"}, 32'(rdata), 32'(e_rd));
  endtask

  // Inputs change just after an edge and are sampled at the next one; outputs are checked 1 time unit after it.
  task automatic step(input logic [1:0] wc, input logic [15:0] wd, input logic [1:0] rt);
    wcount = wc;
    wdata  = wd;
    rtake  = rt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    wcount   = '0;
    wdata    = '0;
    rtake    = '0;

    //             wc    wdata     rt    rc    wcap  rdata
    vecs[0] = '{2'd2, 16'hB2A1, 2'd0, 2'd2, 2'd2, 16'hB2A1};  // first burst
    vecs[1] = '{2'd2, 16'hD4C3, 2'd0, 2'd2, 2'd0, 16'hB2A1};  // fill to 4
    vecs[2] = '{2'd2, 16'hFFEE, 2'd0, 2'd2, 2'd0, 16'hB2A1};  // dropped when full
    vecs[3] = '{2'd0, 16'h0000, 2'd1, 2'd2, 2'd1, 16'hC3B2};  // partial consumption
    vecs[4] = '{2'd2, 16'h2211, 2'd2, 2'd2, 2'd2, 16'h11D4};  // only 0x11 fits
    vecs[5] = '{2'd0, 16'h0000, 2'd2, 2'd0, 2'd2, 16'h0000};  // drain
    vecs[6] = '{2'd1, 16'h9955, 2'd0, 2'd1, 2'd2, 16'h0055};  // unused lane masked
    vecs[7] = '{2'd0, 16'h0000, 2'd2, 2'd0, 2'd2, 16'h0000};  // excess take clipped
    vecs[8] = '{2'd2, 16'h7766, 2'd0, 2'd2, 2'd2, 16'h7766};
    vecs[9] = '{2'd2, 16'h9988, 2'd1, 2'd2, 2'd1, 16'h8877};  // read spans wrap

    #12;
    chk_out("reset", 2'd0, 2'd2, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("idle", 2'd0, 2'd2, 16'h0000);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].wc, vecs[i].wd, vecs[i].rt);
      chk_out($sformatf("vec%0d", i), vecs[i].e_rc, vecs[i].e_wc, vecs[i].e_rd);
    end

    // Async reset with occ=3: outputs clear before any clock edge.
    wcount = '0;
    wdata  = '0;
    rtake  = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("midreset", 2'd0, 2'd2, 16'h0000);
    #2;
    rst_n = 1'b1;
    step(2'd1, 16'h00A1, 2'd0);
    chk_out("post_reset_wr", 2'd1, 2'd2, 16'h00A1);
    step(2'd0, 16'h0000, 2'd1);
    chk_out("post_reset_drain", 2'd0, 2'd2, 16'h0000);

    // Streaming one-in one-out across several pointer wraps.
    for (int i = 0; i < 10; i++) begin
      step(2'd1, 16'(i + 1), (i == 0) ? 2'd0 : 2'd1);
      chk_out($sformatf("stream%0d", i), 2'd1, 2'd2, 16'(i + 1));
    end
    step(2'd0, 16'h0000, 2'd1);
    chk_out("stream_drain", 2'd0, 2'd2, 16'h0000);

`ifdef WARP_LANE_SKID_FLUSH_EN
    step(2'd2, 16'h3231, 2'd0);
    step(2'd1, 16'h0033, 2'd0);
    chk_out("pre_flush", 2'd2, 2'd1, 16'h3231);
    flush = 1'b1;
    step(2'd2, 16'h4443, 2'd1);
    flush = 1'b0;
    chk_out("flush", 2'd0, 2'd2, 16'h0000);
    step(2'd1, 16'h005A, 2'd0);
    chk_out("post_flush_wr", 2'd1, 2'd2, 16'h005A);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
